onehot_decode_fifo: RTL and testbench

// - Receiving end of the 4-bit/2-bit code path: accepts 2-bit codes and returns one-hot 4-bit words.
// - Codes arrive on a valid/ready stream, are buffered in a small FIFO, and are decoded on the output side.
// - Each delivered code is counted in a per-code counter for debug readback.
// - Sits between the code producer and any one-hot consumer; isolates the two sides from backpressure.

---
 rtl/onehot_decode_fifo.sv | 102 ++++++++++
 tb/tb_onehot_decode_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decode_fifo.sv
// Small valid/ready FIFO of 2-bit codes with a one-hot decoded head and
// per-code saturating delivery counters for debug readback.
module onehot_decode_fifo #(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_onehot,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    input  logic             cnt_clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int PTR_W = LVL_W - 1;

    typedef logic [1:0] code_t;

    code_t            mem_q [DEPTH];
    code_t            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic  push;
    logic  pop;
    code_t head_code;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign in_ready   = (level_q != LVL_W'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign head_code  = mem_q[rd_ptr_q];
    assign out_onehot = out_valid ? (4'b0001 << head_code) : 4'b0000;
    assign level      = level_q;
    assign cnt_out    = cnt_q[cnt_sel];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_code;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear wins over a same-cycle delivery.
        if (cnt_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
        end else if (pop && (cnt_q[head_code] != '1)) begin
            cnt_d[head_code] = cnt_q[head_code] + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; level decides which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_onehot_decode_fifo.sv
// Directed bench for onehot_decode_fifo (DEPTH=4, CNT_W=3) with immediate assertions.
module tb_onehot_decode_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [1:0]       in_code;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_onehot;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic             cnt_clr;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    int checks = 0;
    int errors = 0;

    onehot_decode_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .level      (level),
        .cnt_clr    (cnt_clr),
        .cnt_sel    (cnt_sel),
        .cnt_out    (cnt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        #1;
        check(tag, 32'(cnt_out), exp);
    endtask

    logic [1:0]  wrap_codes [10];
    logic [31:0] wrap_ready;
    logic [1:0]  model_q [$];
    int          sent;
    int          delivered;
    int          cyc;
    logic        m_push;
    logic        m_pop;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd2;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        cnt_sel   = 2'd0;

        // Reset held while pushing
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_onehot", 32'(out_onehot), 0);
        check("rst_level", 32'(level), 0);
        check_cnt("rst_cnt0", 2'd0, 0);
        check_cnt("rst_cnt1", 2'd1, 0);
        check_cnt("rst_cnt2", 2'd2, 0);
        check_cnt("rst_cnt3", 2'd3, 0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;

        // Single pass 0,1,2,3 with out_ready=1
        in_valid = 1'b1;
        in_code  = 2'd0;
        tick();
        check("sp_valid0", 32'(out_valid), 1);
        check("sp_onehot0", 32'(out_onehot), 32'b0001);
        check("sp_level0", 32'(level), 1);
        in_code = 2'd1;
        tick();
        check("sp_onehot1", 32'(out_onehot), 32'b0010);
        check("sp_level1", 32'(level), 1);
        in_code = 2'd2;
        tick();
        check("sp_onehot2", 32'(out_onehot), 32'b0100);
        in_code = 2'd3;
        tick();
        check("sp_onehot3", 32'(out_onehot), 32'b1000);
        in_valid = 1'b0;
        in_code  = 2'bxx;
        tick();
        check("sp_empty_valid", 32'(out_valid), 0);
        check("sp_empty_onehot", 32'(out_onehot), 0);
        check("sp_empty_level", 32'(level), 0);
        check_cnt("sp_cnt0", 2'd0, 1);
        check_cnt("sp_cnt1", 2'd1, 1);
        check_cnt("sp_cnt2", 2'd2, 1);
        check_cnt("sp_cnt3", 2'd3, 1);

        // Full / backpressure: six pushes, four accepted (1,2,3,0)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code = 2'd1; tick(); check("full_lvl1", 32'(level), 1);
        in_code = 2'd2; tick(); check("full_lvl2", 32'(level), 2);
        in_code = 2'd3; tick(); check("full_lvl3", 32'(level), 3);
        check("full_ready3", 32'(in_ready), 1);
        in_code = 2'd0; tick(); check("full_lvl4", 32'(level), 4);
        check("full_ready4", 32'(in_ready), 0);
        in_code = 2'd1; tick();
        in_code = 2'd2; tick();
        check("full_lvl_hold", 32'(level), 4);
        check("full_head", 32'(out_onehot), 32'b0010);

        // Pop + push while full: no push, level drops to 3
        out_ready = 1'b1;
        in_code   = 2'd3;
        tick();
        check("fullpp_level", 32'(level), 3);
        check("fullpp_ready", 32'(in_ready), 1);
        check("fullpp_head", 32'(out_onehot), 32'b0100);
        in_valid = 1'b0;
        tick();
        check("drain_head3", 32'(out_onehot), 32'b1000);
        tick();
        check("drain_head0", 32'(out_onehot), 32'b0001);
        tick();
        check("drain_level", 32'(level), 0);
        check_cnt("drain_cnt1", 2'd1, 2);
        check_cnt("drain_cnt0", 2'd0, 2);

        // Wrap: 10 codes under a fixed irregular out_ready pattern, queue scoreboard
        wrap_codes = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        wrap_ready = 32'b1111_1101_0110_0011_1010_0100_1100_1010;
        sent       = 0;
        delivered  = 0;
        cyc        = 0;
        while ((delivered < 10) && (cyc < 60)) begin
            in_valid  = (sent < 10);
            in_code   = (sent < 10) ? wrap_codes[sent] : 2'd0;
            out_ready = wrap_ready[cyc % 32];
            #1;
            check("wrap_level", 32'(level), 32'(model_q.size()));
            check("wrap_onehot", 32'(out_onehot),
                  (model_q.size() != 0) ? (32'd1 << model_q[0]) : 32'd0);
            m_push = in_valid && (model_q.size() != DEPTH);
            m_pop  = out_ready && (model_q.size() != 0);
            tick();
            if (m_pop) begin
                void'(model_q.pop_front());
                delivered++;
            end
            if (m_push) begin
                model_q.push_back(wrap_codes[sent]);
                sent++;
            end
            cyc++;
        end
        check("wrap_delivered", 32'(delivered), 10);
        check("wrap_level_end", 32'(level), 0);
        in_valid = 1'b0;
        check_cnt("wrap_cnt0", 2'd0, 4);
        check_cnt("wrap_cnt1", 2'd1, 5);
        check_cnt("wrap_cnt2", 2'd2, 5);
        check_cnt("wrap_cnt3", 2'd3, 4);

        // Clear, then deliver code 1 nine times: saturates at 7
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_cnt("clr_cnt1", 2'd1, 0);
        in_valid = 1'b1;
        in_code  = 2'd1;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("sat_level", 32'(level), 0);
        check_cnt("sat_cnt1", 2'd1, 7);
        check_cnt("sat_cnt2", 2'd2, 0);

        // cnt_clr with a same-cycle pop of code 1; FIFO unaffected
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code = 2'd1; tick();
        in_code = 2'd2; tick();
        in_valid = 1'b0;
        check("clrpop_level_pre", 32'(level), 2);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_cnt("clrpop_cnt1", 2'd1, 0);
        check("clrpop_level", 32'(level), 1);
        check("clrpop_head", 32'(out_onehot), 32'b0100);
        tick();
        check_cnt("clrpop_cnt2", 2'd2, 1);
        check("clrpop_level_end", 32'(level), 0);

        // Async reset mid-stream with level=3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code = 2'd0; tick();
        in_code = 2'd1; tick();
        in_code = 2'd2; tick();
        in_valid = 1'b0;
        check("ar_level_pre", 32'(level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_level", 32'(level), 0);
        check("ar_onehot", 32'(out_onehot), 0);
        check("ar_in_ready", 32'(in_ready), 1);
        check_cnt("ar_cnt2", 2'd2, 0);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_code  = 2'd3;
        tick();
        check("ar_fresh_level", 32'(level), 1);
        check("ar_fresh_onehot", 32'(out_onehot), 32'b1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("ar_fresh_drain_level", 32'(level), 0);
        check("ar_fresh_drain_valid", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
